ds_sequencer: RTL and testbench
===============================

DS_SEQUENCER -- requirements
Module: ds_sequencer

Interface
REQ-001 SHALL have parameter DW, default 16, data stack word width.
REQ-002 SHALL have parameter DEPTH, default 16, data stack capacity in words.
REQ-003 SHALL have clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have async_reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have cmd_valid  input  1  command offered.
REQ-006 SHALL have cmd_ready  output  1  sequencer can accept a command.
REQ-007 SHALL have cmd_op  input  4  opcode: 0 NOP, 1 PUSH, 2 DROP, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 CMP; all other values illegal.
REQ-008 SHALL have cmd_imm  input  DW  PUSH immediate.
REQ-009 SHALL have status_in  input  2  datapath compare status: 00 equal, 01 A<B, 10 A>B.
REQ-010 SHALL have DSOP  output  4  stack op: [3] pop, [2] push, [1] write, [0] read.
REQ-011 SHALL have ds_data  output  DW  stack write data.
REQ-012 SHALL have ALUOP  output  3  000 add, 001 sub, 010 and, 110 or, 100 compare.
REQ-013 SHALL have done  output  1  one-cycle pulse on command completion.
REQ-014 SHALL have err  output  1  one-cycle pulse on rejected command.
REQ-015 SHALL have depth  output  $clog2(DEPTH+1)  words currently on the stack.
REQ-016 SHALL have cmp_flags  output  2  last captured compare status.

Function
REQ-017 SHALL implement states IDLE, EXEC, WB, ERR; cmd_ready SHALL be 1 only in IDLE.
REQ-018 Handshake: command accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_op/cmd_imm latched then; inputs otherwise ignored.
REQ-019 On acceptance, SHALL go to ERR if opcode illegal, PUSH with depth==DEPTH, DROP with depth==0, or ADD/SUB/AND/OR/CMP with depth<2; otherwise to EXEC.
REQ-020 In IDLE and ERR, DSOP SHALL be 0000, ALUOP 000, ds_data 0.
REQ-021 EXEC per latched op: NOP DSOP=0000; PUSH DSOP=0110, ds_data=imm; DROP DSOP=1000; ADD/SUB/AND/OR DSOP=1001 with mapped ALUOP; CMP DSOP=0001, ALUOP=100.
REQ-022 From EXEC: ADD/SUB/AND/OR go to WB; all other ops go to IDLE with done=1 during EXEC.
REQ-023 WB SHALL drive DSOP=0010 with ALUOP held from EXEC, assert done=1, then go to IDLE.
REQ-024 ERR SHALL last exactly one cycle with err=1, done=0, then go to IDLE; depth and cmp_flags unchanged.
REQ-025 Latency: NOP/PUSH/DROP/CMP 1 cycle after acceptance; binary ALU ops 2 cycles; next command acceptable the cycle after done or err.
REQ-026 depth SHALL update on the edge leaving EXEC: PUSH +1, DROP -1, binary ops -1, NOP/CMP unchanged; never below 0 or above DEPTH.
REQ-027 cmp_flags SHALL load status_in on the edge leaving EXEC for CMP only.
REQ-028 done and err SHALL never both be 1.

Reset
REQ-029 async_reset=1 SHALL immediately force state IDLE, DSOP=0000, ALUOP=000, ds_data=0, done=0, err=0, depth=0, cmp_flags=00, latched command cleared, regardless of state.
REQ-030 Reset mid-command SHALL abandon the command with no done, err, or depth change.
REQ-031 After deassertion cmd_ready SHALL be 1 on the first clock.

Verification
REQ-032 Reset, PUSH imm=5 twice -> DSOP=0110, ds_data=5 for one cycle each, done pulses, depth=2.
REQ-033 Depth 2, ADD -> EXEC DSOP=1001 ALUOP=000, WB DSOP=0010 ALUOP=000 with done, depth=1, cmd_ready low 2 cycles.
REQ-034 Depth 2, CMP with status_in=10 -> DSOP=0001 ALUOP=100 one cycle, cmp_flags=10, depth=2.
REQ-035 Depth 0 DROP, depth 1 SUB, opcode 3, and PUSH at depth 16 -> each err pulse, DSOP=0000, depth unchanged.
REQ-036 async_reset during WB of OR at depth 3 -> DSOP=0000 immediately, no done, depth=0, cmd_ready=1 next clock.
REQ-037 cmd_valid held high across back-to-back PUSH 1, PUSH 2, AND -> one acceptance per IDLE cycle, depth 1,2,1, no lost or duplicated command.

Source files
------------

// File: rtl/ds_sequencer_if.sv
// rtl/ds_sequencer_if.sv - command, datapath-control and status bundle of the data stack sequencer
interface ds_sequencer_if #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH + 1);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_op;
  logic [DW-1:0] cmd_imm;
  logic [1:0]    status_in;
  logic [3:0]    DSOP;
  logic [DW-1:0] ds_data;
  logic [2:0]    ALUOP;
  logic          done;
  logic          err;
  logic [AW-1:0] depth;
  logic [1:0]    cmp_flags;

  // Command issuer side
  modport master (
    output cmd_valid, cmd_op, cmd_imm, status_in,
    input  cmd_ready, DSOP, ds_data, ALUOP, done, err, depth, cmp_flags
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_imm, status_in,
    output cmd_ready, DSOP, ds_data, ALUOP, done, err, depth, cmp_flags
  );
endinterface

// File: rtl/ds_sequencer.sv
// rtl/ds_sequencer.sv - data stack command sequencer driving stack and ALU control
module ds_sequencer #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input logic      clk,
  input logic      async_reset,
  ds_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH + 1);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_DROP = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [AW-1:0] depth_q, depth_d;
  logic [1:0]    cmp_q, cmp_d;

  logic          ready_c, done_c, err_c;
  logic [3:0]    dsop_c;
  logic [2:0]    aluop_c;
  logic [DW-1:0] data_c;
  logic          is_bin_in, is_legal_in, reject_in;

  // ALU encoding for the two-operand ops; compare has its own code
  function automatic logic [2:0] alu_map(input logic [3:0] op);
    case (op)
      OP_SUB:  alu_map = 3'b001;
      OP_AND:  alu_map = 3'b010;
      OP_OR:   alu_map = 3'b110;
      default: alu_map = 3'b000;
    endcase
  endfunction

  // Reject decision made from the offered opcode against the current depth
  always_comb begin
    is_bin_in   = bus.cmd_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
    is_legal_in = is_bin_in || (bus.cmd_op inside {OP_NOP, OP_PUSH, OP_DROP, OP_CMP});
    reject_in   = !is_legal_in
                || (bus.cmd_op == OP_PUSH && depth_q == AW'(DEPTH))
                || (bus.cmd_op == OP_DROP && depth_q == '0)
                || ((is_bin_in || bus.cmd_op == OP_CMP) && depth_q < AW'(2));
  end

  // Next-state, latched command, depth/flag updates and decoded outputs
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imm_d   = imm_q;
    depth_d = depth_q;
    cmp_d   = cmp_q;
    ready_c = 1'b0;
    done_c  = 1'b0;
    err_c   = 1'b0;
    dsop_c  = 4'b0000;
    aluop_c = 3'b000;
    data_c  = '0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.cmd_valid) begin
          op_d    = bus.cmd_op;
          imm_d   = bus.cmd_imm;
          state_d = reject_in ? ERR : EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        case (op_q)
          OP_PUSH: begin
            dsop_c  = 4'b0110;
            data_c  = imm_q;
            done_c  = 1'b1;
            depth_d = depth_q + AW'(1);
          end
          OP_DROP: begin
            dsop_c  = 4'b1000;
            done_c  = 1'b1;
            depth_d = depth_q - AW'(1);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            dsop_c  = 4'b1001;
            aluop_c = alu_map(op_q);
            depth_d = depth_q - AW'(1);
            state_d = WB;
          end
          OP_CMP: begin
            dsop_c  = 4'b0001;
            aluop_c = 3'b100;
            cmp_d   = bus.status_in;
            done_c  = 1'b1;
          end
          default: done_c = 1'b1;
        endcase
      end
      WB: begin
        dsop_c  = 4'b0010;
        aluop_c = alu_map(op_q);
        done_c  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-command registers; reset abandons any command in flight
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      imm_q   <= '0;
      depth_q <= '0;
      cmp_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      depth_q <= depth_d;
      cmp_q   <= cmp_d;
    end
  end

  assign bus.cmd_ready = ready_c;
  assign bus.DSOP      = dsop_c;
  assign bus.ALUOP     = aluop_c;
  assign bus.ds_data   = data_c;
  assign bus.done      = done_c;
  assign bus.err       = err_c;
  assign bus.depth     = depth_q;
  assign bus.cmp_flags = cmp_q;
endmodule

// File: tb/tb_ds_sequencer.sv
// tb/tb_ds_sequencer.sv - scoreboard bench for the data stack sequencer
module tb_ds_sequencer;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic async_reset = 1'b1;
  always #5 clk = ~clk;

  ds_sequencer_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
  ds_sequencer #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .async_reset(async_reset), .bus(bus)
  );

  typedef struct {
    logic          is_err;
    logic [3:0]    dsop;
    logic          chk_alu;
    logic [2:0]    alu;
    logic          chk_data;
    logic [DW-1:0] data;
    int            lat;
    logic [AW-1:0] dep;
    logic [1:0]    cmp;
    int            acc;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic       pend = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         n_resp = 0;
  int         m_depth = 0;
  logic [1:0] m_cmp = 2'b00;

  // Free-running cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: computes the expected response and pushes it
  task automatic predict(input logic [3:0] op, input logic [DW-1:0] imm, input logic [1:0] st);
    exp_t e;
    logic bin, legal;
    bin   = (op >= 4'd4 && op <= 4'd7);
    legal = (op <= 4'd2) || bin || (op == 4'd8);
    e.acc = cyc; e.is_err = 1'b0; e.dsop = 4'b0000; e.chk_alu = 1'b0; e.alu = 3'b000;
    e.chk_data = 1'b0; e.data = '0; e.lat = 1;
    if (!legal || (op == 4'd1 && m_depth == DEPTH) || (op == 4'd2 && m_depth == 0)
        || ((bin || op == 4'd8) && m_depth < 2)) begin
      e.is_err = 1'b1; e.chk_alu = 1'b1; e.chk_data = 1'b1;
    end else begin
      case (op)
        4'd1: begin e.dsop = 4'b0110; e.chk_data = 1'b1; e.data = imm; m_depth++; end
        4'd2: begin e.dsop = 4'b1000; m_depth--; end
        4'd4, 4'd5, 4'd6, 4'd7: begin
          e.dsop = 4'b0010; e.chk_alu = 1'b1; e.lat = 2; m_depth--;
          case (op)
            4'd4: e.alu = 3'b000;
            4'd5: e.alu = 3'b001;
            4'd6: e.alu = 3'b010;
            default: e.alu = 3'b110;
          endcase
        end
        4'd8: begin e.dsop = 4'b0001; e.chk_alu = 1'b1; e.alu = 3'b100; m_cmp = st; end
        default: ;
      endcase
    end
    e.dep = m_depth[AW-1:0];
    e.cmp = m_cmp;
    sb.push_back(e);
  endtask

  // Response monitor: pops the scoreboard on every done/err pulse
  initial begin
    forever begin
      @(negedge clk);
      if (pend) begin
        tests++;
        if (bus.depth !== cur.dep) begin
          fails++; $display("FAIL depth: got %0d expected %0d", bus.depth, cur.dep);
        end
        tests++;
        if (bus.cmp_flags !== cur.cmp) begin
          fails++; $display("FAIL cmp_flags: got %b expected %b", bus.cmp_flags, cur.cmp);
        end
        pend = 1'b0;
      end
      if (!async_reset && (bus.done === 1'b1 || bus.err === 1'b1)) begin
        tests++;
        if (bus.done && bus.err) begin
          fails++; $display("FAIL done_err_both: done=%b err=%b", bus.done, bus.err);
        end
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_response: done=%b err=%b with empty scoreboard", bus.done, bus.err);
        end else begin
          cur = sb.pop_front();
          n_resp++;
          tests++;
          if (bus.err !== cur.is_err) begin
            fails++; $display("FAIL resp_kind: err=%b expected err=%b", bus.err, cur.is_err);
          end
          tests++;
          if (bus.DSOP !== cur.dsop) begin
            fails++; $display("FAIL resp_dsop: got %b expected %b", bus.DSOP, cur.dsop);
          end
          if (cur.chk_alu) begin
            tests++;
            if (bus.ALUOP !== cur.alu) begin
              fails++; $display("FAIL resp_aluop: got %b expected %b", bus.ALUOP, cur.alu);
            end
          end
          if (cur.chk_data) begin
            tests++;
            if (bus.ds_data !== cur.data) begin
              fails++; $display("FAIL resp_data: got %0d expected %0d", bus.ds_data, cur.data);
            end
          end
          tests++;
          if (cyc - cur.acc != cur.lat) begin
            fails++; $display("FAIL latency: got %0d expected %0d", cyc - cur.acc, cur.lat);
          end
          pend = 1'b1;
        end
      end
    end
  end

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || pend) && k < 30) begin @(posedge clk); k++; end
    tests++;
    if (sb.size() != 0 || pend) begin
      fails++; $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
      sb.delete(); pend = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL ready_timeout: cmd_ready=%b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [DW-1:0] imm, input logic [1:0] st);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_imm = imm; bus.status_in = st;
    predict(op, imm, st);
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [DW-1:0] imm, input logic [1:0] st);
    wait_ready();
    issue(op, imm, st);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    tests++;
    if ({bus.DSOP, bus.ALUOP, bus.done, bus.err, bus.cmp_flags} !== 13'd0 || bus.ds_data !== '0) begin
      fails++; $display("FAIL reset_outputs: DSOP=%b ALUOP=%b done=%b err=%b cmp=%b data=%0d expected zeros",
                        bus.DSOP, bus.ALUOP, bus.done, bus.err, bus.cmp_flags, bus.ds_data);
    end
    tests++;
    if (bus.depth !== '0) begin
      fails++; $display("FAIL reset_depth: got %0d expected 0", bus.depth);
    end
    async_reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_push();
    run_cmd(4'd1, 16'd5, 2'b00);
    run_cmd(4'd1, 16'd5, 2'b00);
  endtask

  task automatic test_add();
    wait_ready();
    issue(4'd4, 16'd0, 2'b00);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    tests++;
    if (bus.DSOP !== 4'b1001 || bus.ALUOP !== 3'b000 || bus.cmd_ready !== 1'b0 || bus.done !== 1'b0) begin
      fails++; $display("FAIL add_exec: DSOP=%b ALUOP=%b ready=%b done=%b expected 1001 000 0 0",
                        bus.DSOP, bus.ALUOP, bus.cmd_ready, bus.done);
    end
    @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b0) begin
      fails++; $display("FAIL add_wb_ready: got %b expected 0", bus.cmd_ready);
    end
    @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++; $display("FAIL add_after_ready: got %b expected 1", bus.cmd_ready);
    end
    drain();
  endtask

  task automatic test_cmp();
    run_cmd(4'd1, 16'd9, 2'b00);
    run_cmd(4'd8, 16'd0, 2'b10);
  endtask

  task automatic test_alu_ops();
    run_cmd(4'd1, 16'd3, 2'b00);
    run_cmd(4'd5, 16'd0, 2'b00);
    run_cmd(4'd1, 16'd4, 2'b00);
    run_cmd(4'd6, 16'd0, 2'b00);
    run_cmd(4'd7, 16'd0, 2'b00);
    run_cmd(4'd0, 16'd0, 2'b11);
    run_cmd(4'd1, 16'hbeef, 2'b00);
    run_cmd(4'd8, 16'd0, 2'b01);
    run_cmd(4'd8, 16'd0, 2'b00);
  endtask

  task automatic test_errors();
    run_cmd(4'd2, 16'd0, 2'b00);
    run_cmd(4'd2, 16'd0, 2'b00);
    run_cmd(4'd2, 16'd0, 2'b00);
    run_cmd(4'd1, 16'd7, 2'b00);
    run_cmd(4'd5, 16'd0, 2'b00);
    run_cmd(4'd3, 16'd0, 2'b00);
    run_cmd(4'd15, 16'd0, 2'b00);
    for (int i = 0; i < DEPTH - 1; i++) run_cmd(4'd1, 16'(i + 100), 2'b00);
    run_cmd(4'd1, 16'd42, 2'b00);
    run_cmd(4'd2, 16'd0, 2'b00);
    run_cmd(4'd1, 16'd43, 2'b00);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    async_reset = 1'b1;
    m_depth = 0; m_cmp = 2'b00;
    @(negedge clk);
    async_reset = 1'b0;
    run_cmd(4'd1, 16'd1, 2'b00);
    run_cmd(4'd1, 16'd2, 2'b00);
    run_cmd(4'd1, 16'd3, 2'b00);
    wait_ready();
    issue(4'd7, 16'd0, 2'b00);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    tests++;
    if (bus.DSOP !== 4'b1001 || bus.ALUOP !== 3'b110) begin
      fails++; $display("FAIL or_exec: DSOP=%b ALUOP=%b expected 1001 110", bus.DSOP, bus.ALUOP);
    end
    @(posedge clk);
    #1;
    tests++;
    if (bus.DSOP !== 4'b0010 || bus.done !== 1'b1) begin
      fails++; $display("FAIL or_wb: DSOP=%b done=%b expected 0010 1", bus.DSOP, bus.done);
    end
    #1 async_reset = 1'b1;
    #1;
    tests++;
    if (bus.DSOP !== 4'b0000 || bus.ALUOP !== 3'b000 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      fails++; $display("FAIL reset_async: DSOP=%b ALUOP=%b done=%b err=%b expected 0000 000 0 0",
                        bus.DSOP, bus.ALUOP, bus.done, bus.err);
    end
    tests++;
    if (bus.depth !== '0) begin
      fails++; $display("FAIL reset_mid_depth: got %0d expected 0", bus.depth);
    end
    sb.delete(); pend = 1'b0;
    m_depth = 0; m_cmp = 2'b00;
    @(negedge clk);
    async_reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.depth !== '0) begin
      fails++; $display("FAIL reset_mid_after: ready=%b done=%b depth=%0d expected 1 0 0",
                        bus.cmd_ready, bus.done, bus.depth);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]    ops[3];
    logic [DW-1:0] imms[3];
    int idx = 0;
    int k = 0;
    int start;
    ops[0] = 4'd1; ops[1] = 4'd1; ops[2] = 4'd6;
    imms[0] = 16'd1; imms[1] = 16'd2; imms[2] = 16'd0;
    start = n_resp;
    while (idx < 3 && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.cmd_ready === 1'b1) begin
        issue(ops[idx], imms[idx], 2'b00);
        idx++;
      end
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    tests++;
    if (n_resp - start != 3 || idx != 3) begin
      fails++; $display("FAIL b2b_count: got %0d responses %0d issued expected 3 3", n_resp - start, idx);
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_imm = '0; bus.status_in = 2'b00;
    test_reset();
    test_push();
    test_add();
    test_cmp();
    test_alu_ops();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
